// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset PC, PC increment,
// fetch FSM state encoding and the instruction-queue entry payload.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_RESET = 32'h0;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2
   } ifetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction queue between fetch and decode.
// Ports: clk, rst (sync, active-low); push/push_pc/push_inst write an entry;
// pop retires the head; flush empties the queue (wins over push and pop);
// count is the occupancy; head_valid/head_pc/head_inst present the head.
// Head outputs come straight from storage, so a push shows up one cycle later.
module ifetch_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [XLEN-1:0]           push_pc,
   input  logic [XLEN-1:0]           push_inst,
   input  logic                      pop,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      head_valid,
   output logic [XLEN-1:0]           head_pc,
   output logic [XLEN-1:0]           head_inst
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Guard against misuse: never write when full, never read when empty.
   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_valid = (count != '0);
   assign head_pc    = mem[rd_ptr].pc;
   assign head_inst  = mem[rd_ptr].inst;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: drives the next PC, issues instruction-memory
// requests, queues responses for decode and handles redirects.
// Ports: clk, rst (sync, active-low); pc_i/npc_o connect to the external
// PC register; redirect_i/redirect_pc_i flush and retarget fetch;
// imem_* is the instruction-memory request/ack handshake; inst_* is the
// valid/ready queue head toward decode.
// Build option IFETCH_PERF_EN adds fetch_cnt_o (accepted pushes) and
// drop_cnt_o (discarded responses).
module ifetch
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic [31:0] npc_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [15:0] drop_cnt_o
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   ifetch_state_t   state;
   ifetch_state_t   state_nxt;
   logic [XLEN-1:0] drop_addr;
   logic [XLEN-1:0] drop_addr_nxt;
   logic [CW-1:0]   count;
   logic            room;
   logic            push;
   logic            pop;
   logic            flush;
   logic            discard;

   assign room = (count < CW'(DEPTH));

   // State and drop-address registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         drop_addr <= '0;
      end else begin
         state     <= state_nxt;
         drop_addr <= drop_addr_nxt;
      end
   end

   // Next-state, request and next-PC decode.
   always_comb begin
      state_nxt     = state;
      drop_addr_nxt = drop_addr;
      npc_o         = pc_i;
      imem_req_o    = 1'b0;
      imem_addr_o   = pc_i;
      push          = 1'b0;
      flush         = 1'b0;
      discard       = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            imem_req_o = room;
            if (redirect_i) begin
               flush = 1'b1;
               npc_o = redirect_pc_i;
               if (room && imem_ack_i) begin
                  discard = 1'b1;
               end else if (room) begin
                  // Outstanding request must still be drained at its old address.
                  state_nxt     = DROP;
                  drop_addr_nxt = pc_i;
               end
            end else if (room && imem_ack_i) begin
               push  = 1'b1;
               npc_o = pc_i + PC_STEP;
            end
         end
         DROP: begin
            imem_req_o  = 1'b1;
            imem_addr_o = drop_addr;
            discard     = imem_ack_i;
            if (redirect_i) begin
               flush = 1'b1;
               npc_o = redirect_pc_i;
            end else if (imem_ack_i) begin
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A redirect-cycle pop is dropped: the flush empties the queue anyway.
   assign pop = inst_valid_o && inst_ready_i && !flush;

   ifetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_pc    (pc_i),
      .push_inst  (imem_rdata_i),
      .pop        (pop),
      .flush      (flush),
      .count      (count),
      .head_valid (inst_valid_o),
      .head_pc    (inst_pc_o),
      .head_inst  (inst_o)
   );

`ifdef IFETCH_PERF_EN
   // Free-running event counters; wrap on overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt_o <= '0;
         drop_cnt_o  <= '0;
      end else begin
         if (push) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         end
         if (discard) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: external PC register and a simple memory
// whose data word is the address XOR a fixed key.
module tb_ifetch;

   localparam logic [31:0] KEY = 32'hDEAD_0000;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        ready;
   logic        ack_en;
   logic        ack_force;
   logic [31:0] pc_rst_val;
`ifdef IFETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [15:0] drop_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   ifetch #(.DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc),
      .npc_o         (npc),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_ack_i    (ack),
      .imem_rdata_i  (rdata),
      .inst_valid_o  (valid),
      .inst_o        (inst),
      .inst_pc_o     (inst_pc),
      .inst_ready_i  (ready)
`ifdef IFETCH_PERF_EN
      ,
      .fetch_cnt_o   (fetch_cnt),
      .drop_cnt_o    (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait memory when enabled; ack_force injects a stray ack.
   assign ack   = ack_force | (ack_en & req);
   assign rdata = addr ^ KEY;

   // External program-counter register.
   always @(posedge clk) begin
      if (!rst) pc <= pc_rst_val;
      else      pc <= npc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; ack_en = 1'b0; ack_force = 1'b0; ready = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0; pc_rst_val = 32'h0;
      repeat (2) step();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_npc", npc, 32'h0);
`ifdef IFETCH_PERF_EN
      check("rst_fetch_cnt", fetch_cnt, 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

      // Reset release, zero-wait ack, decode always ready.
      rst = 1'b1; ack_en = 1'b1;
      step(); #1;
      check("t1_npc0", npc, 32'd4);
      check("t1_addr0", addr, 32'd0);
      check("t1_req0", 32'(req), 32'd1);
      step();
      check("t1_valid", 32'(valid), 32'd1);
      check("t1_ipc0", inst_pc, 32'd0);
      check("t1_inst0", inst, 32'd0 ^ KEY);
      check("t1_npc1", npc, 32'd8);
      step();
      check("t1_ipc1", inst_pc, 32'd4);
      check("t1_inst1", inst, 32'd4 ^ KEY);
      check("t1_npc2", npc, 32'd12);
      step();
      check("t1_ipc2", inst_pc, 32'd8);

      // Decode stalled: queue fills after two pushes, then fetch stops.
      rst = 1'b0; ack_en = 1'b0;
      step();
      check("t2_rst_req", 32'(req), 32'd0);
      check("t2_rst_valid", 32'(valid), 32'd0);
      rst = 1'b1; ack_en = 1'b1; ready = 1'b0;
      step(); #1;
      check("t2_npc0", npc, 32'd4);
      step();
      check("t2_valid", 32'(valid), 32'd1);
      check("t2_ipc_a", inst_pc, 32'd0);
      check("t2_npc1", npc, 32'd8);
      step();
      check("t2_full_req", 32'(req), 32'd0);
      check("t2_full_npc", npc, 32'd8);
      check("t2_full_ipc", inst_pc, 32'd0);
      step();
      check("t2_hold_req", 32'(req), 32'd0);
      check("t2_hold_npc", npc, 32'd8);
      ready = 1'b1;
      step();
      check("t2_pop_ipc", inst_pc, 32'd4);
      check("t2_resume_req", 32'(req), 32'd1);
      check("t2_resume_npc", npc, 32'd12);
      step();
      check("t2_pop2_ipc", inst_pc, 32'd8);
      check("t2_npc2", npc, 32'd16);

      // Ack delayed three cycles: request held steady, PC frozen.
      rst = 1'b0; ack_en = 1'b0;
      step();
      rst = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         check("t3_req", 32'(req), 32'd1);
         check("t3_addr", addr, 32'd0);
         check("t3_npc", npc, 32'd0);
         if (i < 2) step();
      end
      ack_en = 1'b1; #1;
      check("t3_ack_npc", npc, 32'd4);
      step();
      check("t3_valid", 32'(valid), 32'd1);
      check("t3_ipc", inst_pc, 32'd0);

      // Redirect with request pending and no ack: drain in DROP.
      ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; #1;
      check("t4_redir_npc", npc, 32'h100);
      step();
      redirect = 1'b0; #1;
      check("t4_flushed", 32'(valid), 32'd0);
      check("t4_drop_req", 32'(req), 32'd1);
      check("t4_drop_addr", addr, 32'd4);
      check("t4_drop_npc", npc, 32'h100);
      step();
      check("t4_drop_addr2", addr, 32'd4);
      ack_en = 1'b1; #1;
      check("t4_drop_ack_npc", npc, 32'h100);
      step();
      check("t4_no_push", 32'(valid), 32'd0);
      check("t4_new_addr", addr, 32'h100);
      check("t4_new_npc", npc, 32'h104);
`ifdef IFETCH_PERF_EN
      check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t4_fetch_cnt", fetch_cnt, 32'd1);
`endif

      // Redirect + ack + pop in one cycle.
      step();
      check("t5_valid", 32'(valid), 32'd1);
      check("t5_ipc", inst_pc, 32'h100);
      check("t5_npc", npc, 32'h108);
      redirect = 1'b1; redirect_pc = 32'h100; #1;
      check("t5_redir_npc", npc, 32'h100);
      step();
      redirect = 1'b0; ack_en = 1'b0; #1;
      check("t5_empty", 32'(valid), 32'd0);
      check("t5_npc_after", npc, 32'h100);
      check("t5_addr_after", addr, 32'h100);
`ifdef IFETCH_PERF_EN
      check("t5_drop_cnt", 32'(drop_cnt), 32'd2);
      check("t5_fetch_cnt", fetch_cnt, 32'd2);
`endif
      step();
      check("t5_still_empty", 32'(valid), 32'd0);

      // PC wrap at the top of the address space.
      rst = 1'b0; pc_rst_val = 32'hFFFF_FFFC;
      step();
      rst = 1'b1; ack_en = 1'b1;
      step();
      pc_rst_val = 32'h0; #1;
      check("t6_wrap_npc", npc, 32'h0);
      check("t6_wrap_addr", addr, 32'hFFFF_FFFC);
      step();
      check("t6_wrap_ipc", inst_pc, 32'hFFFF_FFFC);
      check("t6_wrap_inst", inst, 32'hFFFF_FFFC ^ KEY);
      check("t6_npc_after", npc, 32'd4);

      // Reset during a pending request; a late ack lands in IDLE.
      ack_en = 1'b0; #1;
      check("t6_pending_req", 32'(req), 32'd1);
      rst = 1'b0;
      step();
      check("t6_rst_req", 32'(req), 32'd0);
      check("t6_rst_valid", 32'(valid), 32'd0);
      rst = 1'b1; ack_force = 1'b1; #1;
      check("t6_idle_npc", npc, 32'h0);
      step();
      ack_force = 1'b0; #1;
      check("t6_late_ack_valid", 32'(valid), 32'd0);
      check("t6_fetch_req", 32'(req), 32'd1);
      check("t6_fetch_npc", npc, 32'h0);
`ifdef IFETCH_PERF_EN
      check("t6_fetch_cnt", fetch_cnt, 32'd0);
`endif
      step();
      check("t6_still_empty", 32'(valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
